serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 163 ++++++++++++++++
 tb/tb_serial_addsub.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, one full-adder stage per clock, LSB first.
// Latency: WIDTH rising edges from operand acceptance to out_valid.
// Backpressure: a single operand set in flight; in_ready is low until the result is taken with out_ready.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    // Counter must index bits 0..WIDTH-1; WIDTH is at least 2 so CW is at least 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand shift registers: bit 0 is always the bit being processed.
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Result bits enter at the MSB and move down; after WIDTH steps bit 0 sits at position 0.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Registered outputs; only rewritten on the step that enters DONE.
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] sum_word;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (last_bit) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake strobes decoded directly from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     ;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

    // Single full-adder stage on the current bit pair plus registered carry
    always_comb begin
        sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        sum_word  = {sum_bit, acc_q[WIDTH-1:1]};
    end

    // Datapath next-state: load on accept, shift/accumulate in RUN, publish on the last bit
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        if (accept) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with op.
            a_sh_d  = a;
            b_sh_d  = op ? ~b : b;
            carry_d = op;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (state_q == RUN) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            acc_d   = sum_word;
            carry_d = carry_nxt;
            if (last_bit) begin
                cnt_d    = '0;
                result_d = sum_word;
                cout_d   = carry_nxt;
                // carry_q is the carry into the MSB at this step.
                ovf_d    = carry_q ^ carry_nxt;
                zero_d   = (sum_word == '0);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised and directed bench for serial_addsub at WIDTH=8 against an arithmetic reference model.
// Latency: checks WIDTH-edge latency and output holding under out_ready backpressure.
// Backpressure: out_ready is held low for random stretches while in_valid is toggled.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    int n_chk = 0;
    int n_err = 0;

    // Last completed result as the model sees it
    logic [W-1:0] prev_r;
    logic         prev_c, prev_v, prev_z;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow
    function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                                   output logic [W-1:0] r, output logic c, output logic v,
                                   output logic z);
        int u;
        int s;
        int sx;
        int sy;
        sx = $signed(x);
        sy = $signed(y);
        if (!o) begin
            u = int'(x) + int'(y);
            c = (u > 255);
            s = sx + sy;
        end else begin
            u = int'(x) - int'(y);
            c = (x >= y);
            s = sx - sy;
        end
        r = u[W-1:0];
        v = (s > 127) || (s < -128);
        z = (r == '0);
    endfunction

    task automatic check_prev(input string tag);
        chk({tag, "_res"},  32'(result),   32'(prev_r));
        chk({tag, "_cout"}, 32'(cout),     32'(prev_c));
        chk({tag, "_ovf"},  32'(overflow), 32'(prev_v));
        chk({tag, "_zero"}, 32'(zero),     32'(prev_z));
    endtask

    // Launch one operation; returns after acceptance edge (+1 time unit)
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a_i       = x;
        b_i       = y;
        op_i      = o;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_i      = W'($urandom);
        b_i      = W'($urandom);
        op_i     = 1'($urandom);
        chk("in_ready_run", 32'(in_ready), 32'd0);
        // Outputs must still show the previous completed operation.
        check_prev("hold_run");
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                          input int hold);
        logic [W-1:0] er;
        logic ec, ev, ez;
        int lat;
        ref_op(x, y, o, er, ec, ev, ez);
        launch(x, y, o);
        lat = 0;
        while (!out_valid && lat < 40) begin
            // Junk on the input side must be ignored while busy.
            in_valid  = 1'($urandom);
            a_i       = W'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd8);
        prev_r = er;
        prev_c = ec;
        prev_v = ev;
        prev_z = ez;
        check_prev("done");
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            check_prev("stall");
        end
        // Release: an in_valid pulse on this same edge must not be accepted.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        check_prev("idle");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_i      = 1'b0;
        a_i       = '0;
        b_i       = '0;
        prev_r    = '0;
        prev_c    = 1'b0;
        prev_v    = 1'b0;
        prev_z    = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_prev("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(8'h0F, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1);
        run_op(8'h05, 8'h07, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b1, 2);
        run_op(8'h7F, 8'h01, 1'b0, 5);
        chk("dir_7f_res", 32'(result), 32'h80);
        chk("dir_7f_ovf", 32'(overflow), 32'd1);

        // Reset in the middle of RUN, after bits 0..3 are processed
        launch(8'hAA, 8'h11, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        prev_r = '0;
        prev_c = 1'b0;
        prev_v = 1'b0;
        prev_z = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        check_prev("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 0);
        chk("post_rst_res", 32'(result), 32'h46);

        // Randomised operations with random backpressure
        for (int i = 0; i < 200; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
        // Edge operands
        run_op(8'h00, 8'h00, 1'b1, 0);
        run_op(8'h7F, 8'h80, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
